// File: rtl/c_matrix_collector.sv
// Collects an N-wide C result stream into an NxN buffer (overwrite or accumulate)
// and holds the completed matrix for registered random-access readout.

module c_matrix_cell #(
  parameter int CW  = 18,
  parameter int ACW = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic           acc_i,
  input  logic [CW-1:0]  din_i,
  output logic [ACW-1:0] q_o
);
  logic [ACW-1:0] q_q;

  // Accumulation wraps modulo 2^ACW; the stream value is zero-extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (we_i) q_q <= acc_i ? q_q + ACW'(din_i) : ACW'(din_i);
  end

  assign q_o = q_q;
endmodule

module c_matrix_collector #(
  parameter int N            = 4,
  parameter int C_DATA_WIDTH = 18,
  parameter int ACC_WIDTH    = 24,
  localparam int AW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             start_by_row,
  input  logic                             start_accumulate,
  input  logic                             hold,
  input  logic                             stream_valid,
  output logic                             stream_ready,
  output logic                             stream_by_row,
  input  logic [N-1:0][C_DATA_WIDTH-1:0]   stream_data,
  output logic                             busy,
  output logic                             done,
  input  logic                             release_buf,
  input  logic                             rd_en,
  input  logic [AW-1:0]                    rd_row,
  input  logic [AW-1:0]                    rd_col,
  output logic [ACC_WIDTH-1:0]             rd_data
);
  typedef enum logic [1:0] {IDLE, RECV, FULL} state_e;

  state_e                              state_q, state_d;
  logic [AW-1:0]                       k_q, k_d;
  logic                                by_row_q, by_row_d;
  logic                                acc_q, acc_d;
  logic [ACC_WIDTH-1:0]                rd_data_q;
  logic [N-1:0][N-1:0][ACC_WIDTH-1:0]  cell_q;
  logic                                hs;

  assign stream_ready  = (state_q == RECV) && !hold;
  assign hs            = stream_valid && stream_ready;
  assign busy          = (state_q == RECV);
  assign done          = (state_q == FULL);
  assign stream_by_row = by_row_q;
  assign rd_data       = rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      by_row_q <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      by_row_q <= by_row_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    by_row_d = by_row_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: if (start) begin
        by_row_d = start_by_row;
        acc_d    = start_accumulate;
        k_d      = '0;
        state_d  = RECV;
      end
      RECV: if (hs) begin
        if (k_q == AW'(N-1)) begin
          k_d     = '0;
          state_d = FULL;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      FULL: if (release_buf) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row mode: beat k fills row k; column mode: beat k fills column k.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic we;
      assign we = hs && (by_row_q ? (k_q == AW'(i)) : (k_q == AW'(j)));
      c_matrix_cell #(.CW(C_DATA_WIDTH), .ACW(ACC_WIDTH)) u_cell (
        .clk   (clk),
        .rst_n (reset),
        .we_i  (we),
        .acc_i (acc_q),
        .din_i (by_row_q ? stream_data[j] : stream_data[i]),
        .q_o   (cell_q[i][j])
      );
    end
  end

  // Sampling the cell register before its update gives read-old-on-collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= cell_q[rd_row][rd_col];
  end
endmodule

// File: tb/tb_c_matrix_collector.sv
// Directed bench for c_matrix_collector: spec-level model with per-cycle compare,
// plus literal expectations and a narrow-accumulator instance for wrap checking.

module tb_c_matrix_collector;
  localparam int N  = 4;
  localparam int CW = 18;
  localparam int AC = 24;
  localparam int unsigned MASK = (32'd1 << AC) - 1;

  logic clk = 1'b0;
  logic reset, start, start_by_row, start_accumulate, hold, stream_valid;
  logic release_buf, rd_en;
  logic [1:0] rd_row, rd_col;
  logic [N-1:0][CW-1:0] sd;
  logic [N-1:0][3:0] sd2;
  logic stream_ready, stream_by_row, busy, done;
  logic [AC-1:0] rd_data;
  logic sr2, sbr2, busy2, done2;
  logic [3:0] rd_data2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  c_matrix_collector #(.N(N), .C_DATA_WIDTH(CW), .ACC_WIDTH(AC)) dut (
    .clk(clk), .reset(reset), .start(start), .start_by_row(start_by_row),
    .start_accumulate(start_accumulate), .hold(hold), .stream_valid(stream_valid),
    .stream_ready(stream_ready), .stream_by_row(stream_by_row), .stream_data(sd),
    .busy(busy), .done(done), .release_buf(release_buf), .rd_en(rd_en),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data));

  c_matrix_collector #(.N(N), .C_DATA_WIDTH(4), .ACC_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start), .start_by_row(start_by_row),
    .start_accumulate(start_accumulate), .hold(hold), .stream_valid(stream_valid),
    .stream_ready(sr2), .stream_by_row(sbr2), .stream_data(sd2),
    .busy(busy2), .done(done2), .release_buf(release_buf), .rd_en(rd_en),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 holding a full matrix.
  int          m_phase, m_k;
  logic        m_row, m_acc;
  int unsigned m_buf [N][N];
  int unsigned m_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_k <= 0; m_row <= 1'b0; m_acc <= 1'b0; m_rd <= 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) m_buf[r][c] <= 0;
    end else begin
      if (rd_en) m_rd <= m_buf[rd_row][rd_col];
      case (m_phase)
        0: if (start) begin
          m_phase <= 1; m_k <= 0; m_row <= start_by_row; m_acc <= start_accumulate;
        end
        1: if (stream_valid && !hold) begin
          for (int j = 0; j < N; j++) begin
            int r, c;
            r = m_row ? m_k : j;
            c = m_row ? j : m_k;
            m_buf[r][c] <= m_acc ? ((m_buf[r][c] + int'(sd[j])) & MASK) : int'(sd[j]);
          end
          if (m_k == N-1) begin m_phase <= 2; m_k <= 0; end
          else m_k <= m_k + 1;
        end
        default: if (release_buf) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("stream_ready", stream_ready, (m_phase == 1) && !hold);
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    check("stream_by_row", stream_by_row, m_row);
    check("rd_data", rd_data, m_rd);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic row, input logic acc);
    start = 1'b1; start_by_row = row; start_accumulate = acc;
    tick();
    start = 1'b0;
  endtask

  task automatic beat_fill(input int base, input int step);
    for (int j = 0; j < N; j++) sd[j] = CW'(base + j * step);
  endtask

  task automatic rd(input int r, input int c);
    rd_en = 1'b1; rd_row = 2'(r); rd_col = 2'(c);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic send_seq(input int base);
    stream_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      beat_fill(base + k * N, 1);
      tick();
    end
    stream_valid = 1'b0;
  endtask

  task automatic do_release();
    release_buf = 1'b1;
    tick();
    release_buf = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 0; start_by_row = 0; start_accumulate = 0; hold = 0;
    stream_valid = 0; release_buf = 0; rd_en = 0; rd_row = 0; rd_col = 0;
    sd = '0; sd2 = '0;
    tick(); tick();
    check("reset busy", busy, 0);
    check("reset rd_data", rd_data, 0);
    reset = 1'b1;
    tick();

    // Row overwrite with 1..16
    do_start(1'b1, 1'b0);
    check("busy after start", busy, 1);
    send_seq(1);
    check("done after 4 beats", done, 1);
    check("busy after 4 beats", busy, 0);
    check("by_row row mode", stream_by_row, 1);
    stream_valid = 1'b1; beat_fill(99, 0);
    tick();
    stream_valid = 1'b0;
    do_start(1'b0, 1'b1);
    check("start in FULL ignored by_row", stream_by_row, 1);
    check("start in FULL done", done, 1);
    rd(2, 1);
    check("row read (2,1)", rd_data, 10);
    rd(3, 3);
    check("no 5th beat (3,3)", rd_data, 16);
    release_buf = 1'b1; start = 1'b1;
    tick();
    release_buf = 1'b0; start = 1'b0;
    check("release+start done", done, 0);
    check("release+start busy", busy, 0);
    do_release();
    check("release in IDLE busy", busy, 0);

    // Column overwrite; a start mid-RECV must not change direction
    do_start(1'b0, 1'b0);
    stream_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      beat_fill(1 + k * N, 1);
      start = (k == 2); start_by_row = 1'b1;
      tick();
    end
    start = 1'b0; stream_valid = 1'b0;
    check("col by_row", stream_by_row, 0);
    rd(2, 1);
    check("col read (2,1)", rd_data, 7);
    do_release();

    // Overwrite 5s (15s on narrow), then accumulate 3s
    do_start(1'b1, 1'b0);
    stream_valid = 1'b1; beat_fill(5, 0); sd2 = {N{4'd15}};
    for (int k = 0; k < N; k++) tick();
    stream_valid = 1'b0;
    do_release();
    do_start(1'b1, 1'b1);
    stream_valid = 1'b1; beat_fill(3, 0); sd2 = {N{4'd3}};
    for (int k = 0; k < N; k++) tick();
    stream_valid = 1'b0; sd2 = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) rd(r, c);
    rd(1, 2);
    check("acc 5+3", rd_data, 8);
    check("acc wrap 15+3", rd_data2, 2);
    do_release();

    // Backpressure on RECV cycles 2-3, with a same-edge read of a written cell
    begin
      int idx, cyc;
      logic hs;
      do_start(1'b1, 1'b0);
      idx = 0; cyc = 1;
      while (idx < N && cyc < 20) begin
        stream_valid = 1'b1;
        hold = (cyc == 2) || (cyc == 3);
        beat_fill(100 + idx * N, 1);
        rd_en = (cyc == 1); rd_row = 0; rd_col = 0;
        #1;
        if (hold) check("ready low under hold", stream_ready, 0);
        hs = stream_valid && stream_ready;
        tick();
        rd_en = 1'b0;
        if (cyc == 1) check("read-during-write old", rd_data, 8);
        if (hs) idx++;
        cyc++;
      end
      stream_valid = 1'b0; hold = 1'b0;
      check("backpressure cycles", cyc, 7);
      check("backpressure done", done, 1);
      rd(0, 0);
      check("new value after write", rd_data, 100);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) rd(r, c);
      check("bp order (3,3)", rd_data, 115);
      do_release();
    end

    // Asynchronous reset after two beats
    do_start(1'b1, 1'b0);
    stream_valid = 1'b1;
    beat_fill(200, 1); tick();
    beat_fill(210, 1); tick();
    stream_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst ready", stream_ready, 0);
    check("async rst by_row", stream_by_row, 0);
    check("async rst rd_data", rd_data, 0);
    @(posedge clk); #1 reset = 1'b1;
    tick();
    do_start(1'b1, 1'b0);
    send_seq(40);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) rd(r, c);
    rd(1, 3);
    check("post-reset (1,3)", rd_data, 47);
    do_release();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
